// File: rtl/pmem_burst_adaptor.sv
// Line-to-burst adaptor: turns 256-bit L2 line fill/writeback requests into BEATS-beat memory bursts.
// Optional ADAPTOR_PERF_CNT_EN adds saturating completed read/write transfer counters.
module pmem_burst_adaptor #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    line_read,
  input  logic                    line_write,
  input  logic [ADDR_W-1:0]       line_address,
  input  logic [BEATS*BEAT_W-1:0] line_wdata,
  output logic [BEATS*BEAT_W-1:0] line_rdata,
  output logic                    line_resp,
  output logic                    burst_read,
  output logic                    burst_write,
  output logic [ADDR_W-1:0]       burst_address,
  output logic [BEAT_W-1:0]       burst_wdata,
  input  logic [BEAT_W-1:0]       burst_rdata,
  input  logic                    burst_resp,
  output logic [31:0]             rd_bursts,
  output logic [31:0]             wr_bursts
);
  localparam int LINE_W = BEATS * BEAT_W;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [LINE_W-1:0]  r_wline;
  logic [LINE_W-1:0]  r_rdata;
  logic               w_beat_take;
  logic               w_req;

  assign w_req = line_read | line_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    burst_read    = 1'b0;
    burst_write   = 1'b0;
    line_resp     = 1'b0;
    w_beat_take   = 1'b0;
    burst_address = '0;
    burst_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        // A simultaneous read is left for the L2 to re-issue after the writeback.
        if (line_write) begin
          w_state_nxt = S_WR;
        end else if (line_read) begin
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        burst_read    = 1'b1;
        burst_address = r_addr;
        w_beat_take   = burst_resp;
        if (burst_resp && (r_beat_cnt == LAST_BEAT)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_WR: begin
        burst_write   = 1'b1;
        burst_address = r_addr;
        burst_wdata   = r_wline[BEAT_W*r_beat_cnt +: BEAT_W];
        w_beat_take   = burst_resp;
        if (burst_resp && (r_beat_cnt == LAST_BEAT)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        line_resp   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= '0;
      r_addr     <= '0;
      r_wline    <= '0;
      r_rdata    <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_req) begin
        r_addr     <= line_address & ~OFF_MASK;
        r_wline    <= line_wdata;
        r_beat_cnt <= '0;
      end
      if (w_beat_take) begin
        if (r_state == S_RD) begin
          r_rdata[BEAT_W*r_beat_cnt +: BEAT_W] <= burst_rdata;
        end
        r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
      end
    end
  end

  assign line_rdata = r_rdata;

`ifdef ADAPTOR_PERF_CNT_EN
  logic        r_is_wr;
  logic [31:0] r_rd_bursts;
  logic [31:0] r_wr_bursts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_wr     <= 1'b0;
      r_rd_bursts <= '0;
      r_wr_bursts <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_req) begin
        r_is_wr <= line_write;
      end
      if (r_state == S_DONE) begin
        if (r_is_wr && (r_wr_bursts != 32'hFFFF_FFFF)) begin
          r_wr_bursts <= r_wr_bursts + 32'd1;
        end else if (!r_is_wr && (r_rd_bursts != 32'hFFFF_FFFF)) begin
          r_rd_bursts <= r_rd_bursts + 32'd1;
        end
      end
    end
  end

  assign rd_bursts = r_rd_bursts;
  assign wr_bursts = r_wr_bursts;
`else
  assign rd_bursts = 32'h0;
  assign wr_bursts = 32'h0;
`endif

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Scoreboarded bench for pmem_burst_adaptor: a memory responder with random gaps, a line-level
// reference model feeding an expected-transaction queue, and a monitor checking beats and line_resp.
module tb_pmem_burst_adaptor;
  localparam int BEATS  = 4;
  localparam int BEAT_W = 64;
  localparam int ADDR_W = 32;
  localparam int LINE_W = BEATS * BEAT_W;
  localparam int TMO    = 400;

  logic              clk;
  logic              rst;
  logic              line_read;
  logic              line_write;
  logic [ADDR_W-1:0] line_address;
  logic [LINE_W-1:0] line_wdata;
  logic [LINE_W-1:0] line_rdata;
  logic              line_resp;
  logic              burst_read;
  logic              burst_write;
  logic [ADDR_W-1:0] burst_address;
  logic [BEAT_W-1:0] burst_wdata;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;
  logic [31:0]       rd_bursts;
  logic [31:0]       wr_bursts;

  pmem_burst_adaptor #(.BEATS(BEATS), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp),
    .rd_bursts(rd_bursts), .wr_bursts(wr_bursts)
  );

  typedef struct {
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] line;
  } exp_t;

  exp_t              exp_q[$];
  logic [BEAT_W-1:0] rd_beat_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int gap_mode = 0;
  int gap_left = 0;
  int idle_pulses = 0;
  int beat_idx = 0;
  int n_rd_done = 0;
  int n_wr_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic finish_up();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Memory side: answers active bursts with configurable gaps, plus optional stray idle pulses.
  initial begin
    burst_resp  = 1'b0;
    burst_rdata = '0;
    forever begin
      @(negedge clk);
      burst_resp  = 1'b0;
      burst_rdata = {$urandom, $urandom};
      if (rst === 1'b0) begin
        gap_left = 0;
      end else if (burst_read || burst_write) begin
        if (gap_left > 0) begin
          gap_left--;
        end else begin
          burst_resp = 1'b1;
          if (burst_read && rd_beat_q.size() > 0) burst_rdata = rd_beat_q.pop_front();
          gap_left = (gap_mode == 2) ? 2 : (gap_mode == 1) ? int'($urandom_range(0, 2)) : 0;
        end
      end else if (idle_pulses > 0) begin
        burst_resp = 1'b1;
        idle_pulses--;
      end
    end
  end

  // Monitor: checks every accepted beat and every line_resp against the expected queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b0) begin
        beat_idx  = 0;
        n_rd_done = 0;
        n_wr_done = 0;
        continue;
      end
      if (exp_q.size() == 0) begin
        chk("idle_no_burst", {254'd0, burst_read, burst_write}, '0);
        chk("idle_no_resp", line_resp, 1'b0);
      end else begin
        e = exp_q[0];
        if ((burst_read || burst_write) && burst_resp) begin
          chk("beat_kind", {burst_read, burst_write}, {!e.is_wr, e.is_wr});
          chk("burst_address", burst_address, e.addr);
          if (e.is_wr) chk("burst_wdata", burst_wdata, e.line[BEAT_W*beat_idx +: BEAT_W]);
          beat_idx++;
        end
        if (line_resp) begin
          void'(exp_q.pop_front());
          chk("beats_per_line", beat_idx, BEATS);
          chk("done_bus_quiet", {burst_read, burst_write, burst_address}, '0);
          if (!e.is_wr) chk("line_rdata", line_rdata, e.line);
          if (e.is_wr) n_wr_done++;
          else n_rd_done++;
          beat_idx = 0;
        end
      end
    end
  end

  task automatic do_txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rline,
                        input bit scramble, output int lat);
    exp_t e;
    e.is_wr = wr;
    e.addr  = addr & ~32'h1F;
    e.line  = wr ? wd : rline;
    if (!wr) for (int i = 0; i < BEATS; i++) rd_beat_q.push_back(rline[BEAT_W*i +: BEAT_W]);
    exp_q.push_back(e);
    line_read    = rd;
    line_write   = wr;
    line_address = addr;
    line_wdata   = wd;
    lat = 0;
    while (!line_resp && lat < TMO) begin
      @(negedge clk);
      lat++;
      if (scramble && !line_resp) begin
        line_address = $urandom;
        line_wdata   = rand_line();
      end
    end
    line_read  = 1'b0;
    line_write = 1'b0;
    if (lat >= TMO) begin
      n_checks++;
      $display("FAIL txn_timeout: no line_resp after %0d cycles, required within %0d", lat, TMO);
      finish_up();
    end
  endtask

  initial begin
    int lat;
    logic [LINE_W-1:0] l;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
    rst = 1'b0;
    line_read = 1'b0;
    line_write = 1'b0;
    line_address = '0;
    line_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {line_resp, burst_read, burst_write, burst_address, burst_wdata}, '0);
    chk("reset_rdata", line_rdata, '0);
    chk("reset_counters", {rd_bursts, wr_bursts}, '0);
    rst = 1'b1;
    @(negedge clk);

    gap_mode = 0;
    gap_left = 0;
    l = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    do_txn(1'b1, 1'b0, 32'h0000_1234, '0, l, 1'b0, lat);
    chk("read_latency", lat, BEATS + 1);
    @(negedge clk);

    gap_mode = 2;
    gap_left = 0;
    l = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    do_txn(1'b0, 1'b1, 32'h0000_4567, l, '0, 1'b1, lat);
    chk("write_gap_latency", lat, 11);
    @(negedge clk);

    gap_mode = 0;
    gap_left = 0;
    do_txn(1'b1, 1'b1, 32'h0000_0080, rand_line(), rand_line(), 1'b0, lat);
    @(negedge clk);
    do_txn(1'b1, 1'b0, 32'h0000_0080, '0, rand_line(), 1'b0, lat);
    @(negedge clk);

    idle_pulses = 3;
    repeat (6) @(negedge clk);
    chk("stray_resp_consumed", idle_pulses, 0);

    // Reset after two read beats have been taken.
    begin
      exp_t e;
      l = rand_line();
      e.is_wr = 1'b0;
      e.addr  = 32'h0000_2000;
      e.line  = l;
      for (int i = 0; i < BEATS; i++) rd_beat_q.push_back(l[BEAT_W*i +: BEAT_W]);
      exp_q.push_back(e);
      line_read = 1'b1;
      line_address = 32'h0000_2000;
      lat = 0;
      while (beat_idx < 2 && lat < TMO) begin
        @(negedge clk);
        lat++;
      end
      chk("two_beats_before_reset", beat_idx, 2);
      rst = 1'b0;
      line_read = 1'b0;
      #2;
      chk("midburst_reset_outputs", {line_resp, burst_read, burst_write, burst_address, burst_wdata}, '0);
      chk("midburst_reset_rdata", line_rdata, '0);
      exp_q.delete();
      rd_beat_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
    end
    do_txn(1'b1, 1'b0, 32'h0000_2008, '0, rand_line(), 1'b0, lat);
    chk("read_after_reset_latency", lat, BEATS + 1);

    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      gap_mode = int'($urandom_range(0, 2));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        idle_pulses = int'($urandom_range(1, 3));
        repeat (4) @(negedge clk);
      end
      do_txn(kind != 1, kind != 0, $urandom, rand_line(), rand_line(), $urandom_range(0, 1) == 1, lat);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
`ifdef ADAPTOR_PERF_CNT_EN
    exp_rd = n_rd_done;
    exp_wr = n_wr_done;
`else
    exp_rd = 32'h0;
    exp_wr = 32'h0;
`endif
    chk("rd_bursts", rd_bursts, exp_rd);
    chk("wr_bursts", wr_bursts, exp_wr);
    finish_up();
  end

  initial begin
    #500000;
    n_checks++;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion earlier", $time);
    finish_up();
  end

endmodule
